// File: rtl/sca_regif_pkg.sv
// Shared definitions for the AXI4-Lite cipher register front end:
// register map, control/status bit positions and AXI response codes.
package sca_regif_pkg;

   localparam int REG_CTRL   = 0;
   localparam int REG_STATUS = 1;
   localparam int REG_CYCLES = 2;
   localparam int REG_ID     = 3;

   localparam int CTRL_START   = 0;
   localparam int CTRL_TRIG_EN = 1;

   localparam int STATUS_BUSY = 0;
   localparam int STATUS_DONE = 1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // First key word sits right after the four fixed registers.
   function automatic int keyBase();
      return 4;
   endfunction

   function automatic int ptBase(input int keyWords);
      return 4 + keyWords;
   endfunction

   function automatic int ctBase(input int keyWords, input int blkWords);
      return 4 + keyWords + blkWords;
   endfunction

   // One past the last mapped register index.
   function automatic int regEnd(input int keyWords, input int blkWords);
      return 4 + keyWords + 2 * blkWords;
   endfunction

   // Byte-lane merge of a write into an existing 32-bit register.
   function automatic logic [31:0] mergeStrb(input logic [31:0] oldVal,
                                             input logic [31:0] newVal,
                                             input logic [3:0]  strb);
      logic [31:0] res;
      res = oldVal;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[8*b +: 8] = newVal[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/sca_axil_cipher_regif_if.sv
// AXI4-Lite bus bundle between the interconnect (master) and the
// cipher register front end (slave).
interface sca_axil_cipher_regif_if #(
   parameter int ADDR_W = 6
) ();

   logic [ADDR_W-1:0] AWADDR;
   logic [2:0]        AWPROT;
   logic              AWVALID;
   logic              AWREADY;
   logic [31:0]       WDATA;
   logic [3:0]        WSTRB;
   logic              WVALID;
   logic              WREADY;
   logic [1:0]        BRESP;
   logic              BVALID;
   logic              BREADY;
   logic [ADDR_W-1:0] ARADDR;
   logic [2:0]        ARPROT;
   logic              ARVALID;
   logic              ARREADY;
   logic [31:0]       RDATA;
   logic [1:0]        RRESP;
   logic              RVALID;
   logic              RREADY;

   modport master (
      output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
      output ARADDR, ARPROT, ARVALID, RREADY,
      input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );

   modport slave (
      input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
      input  ARADDR, ARPROT, ARVALID, RREADY,
      output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );

endinterface

// File: rtl/sca_axil_slave_if.sv
// AXI4-Lite slave channel handling: joins AW and W into one register write,
// holds B and R responses until accepted, one write and one read outstanding.
module sca_axil_slave_if
   import sca_regif_pkg::*;
#(
   parameter int ADDR_W = 6
) (
   input  logic              ACLK,
   input  logic              ARESET,
   sca_axil_cipher_regif_if.slave S_AXI,
   output logic              wr_en,
   output logic [ADDR_W-3:0] wr_idx,
   output logic [31:0]       wr_data,
   output logic [3:0]        wr_strb,
   input  logic              wr_err,
   output logic              rd_en,
   output logic [ADDR_W-3:0] rd_idx,
   input  logic [31:0]       rd_data,
   input  logic              rd_err
);

   logic        awReady_q;
   logic        bValid_q;
   logic [1:0]  bResp_q;
   logic        arReady_q;
   logic        rValid_q;
   logic [1:0]  rResp_q;
   logic [31:0] rData_q;
   logic        unusedBits;

   assign unusedBits = ^{S_AXI.AWPROT, S_AXI.ARPROT, S_AXI.AWADDR[1:0], S_AXI.ARADDR[1:0]};

   assign wr_en   = awReady_q & S_AXI.AWVALID & S_AXI.WVALID;
   assign wr_idx  = S_AXI.AWADDR[ADDR_W-1:2];
   assign wr_data = S_AXI.WDATA;
   assign wr_strb = S_AXI.WSTRB;

   assign rd_en  = arReady_q & S_AXI.ARVALID;
   assign rd_idx = S_AXI.ARADDR[ADDR_W-1:2];

   assign S_AXI.AWREADY = awReady_q;
   assign S_AXI.WREADY  = awReady_q;
   assign S_AXI.BVALID  = bValid_q;
   assign S_AXI.BRESP   = bResp_q;
   assign S_AXI.ARREADY = arReady_q;
   assign S_AXI.RVALID  = rValid_q;
   assign S_AXI.RDATA   = rData_q;
   assign S_AXI.RRESP   = rResp_q;

   // Write side: one-cycle joint AW/W ready once both are valid and no B is pending.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         awReady_q <= 1'b0;
         bValid_q  <= 1'b0;
         bResp_q   <= RESP_OKAY;
      end else begin
         if (awReady_q) begin
            awReady_q <= 1'b0;
         end else if (S_AXI.AWVALID && S_AXI.WVALID && !bValid_q) begin
            awReady_q <= 1'b1;
         end
         if (wr_en) begin
            bValid_q <= 1'b1;
            bResp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
         end else if (bValid_q && S_AXI.BREADY) begin
            bValid_q <= 1'b0;
         end
      end
   end

   // Read side: data is sampled on the address handshake, so a same-edge write is not visible.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         arReady_q <= 1'b0;
         rValid_q  <= 1'b0;
         rResp_q   <= RESP_OKAY;
         rData_q   <= '0;
      end else begin
         if (arReady_q) begin
            arReady_q <= 1'b0;
         end else if (S_AXI.ARVALID && !rValid_q) begin
            arReady_q <= 1'b1;
         end
         if (rd_en) begin
            rValid_q <= 1'b1;
            rData_q  <= rd_data;
            rResp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
         end else if (rValid_q && S_AXI.RREADY) begin
            rValid_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/sca_axil_cipher_regif.sv
// AXI4-Lite register front end for a block-cipher core: key/plaintext/ciphertext
// banks, control/status, busy-cycle counter, ID and a busy-qualified scope trigger.
module sca_axil_cipher_regif
   import sca_regif_pkg::*;
#(
   parameter int          C_S_AXI_DATA_WIDTH = 32,
   parameter int          C_S_AXI_ADDR_WIDTH = 6,
   parameter int          KEY_WORDS          = 4,
   parameter int          BLK_WORDS          = 4,
   parameter logic [31:0] CORE_ID            = 32'h0000_0000
) (
   input  logic                   ACLK,
   input  logic                   ARESET,
   sca_axil_cipher_regif_if.slave S_AXI,
   output logic                   core_start,
   output logic [32*KEY_WORDS-1:0] core_key,
   output logic [32*BLK_WORDS-1:0] core_din,
   input  logic                   core_done,
   input  logic [32*BLK_WORDS-1:0] core_dout,
   output logic                   trigger
);

   localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
   localparam int KB    = keyBase();
   localparam int PB    = ptBase(KEY_WORDS);
   localparam int CB    = ctBase(KEY_WORDS, BLK_WORDS);
   localparam int EB    = regEnd(KEY_WORDS, BLK_WORDS);

   logic             wr_en;
   logic [IDX_W-1:0] wr_idx;
   logic [31:0]      wr_data;
   logic [3:0]       wr_strb;
   logic             wr_err;
   logic             rd_en;
   logic [IDX_W-1:0] rd_idx;
   logic [C_S_AXI_DATA_WIDTH-1:0] rdData;
   logic             rd_err;
   int               wrSel;
   int               rdSel;

   logic [KEY_WORDS-1:0][31:0] key_q, key_d;
   logic [BLK_WORDS-1:0][31:0] pt_q, pt_d;
   logic [BLK_WORDS-1:0][31:0] ct_q, ct_d;
   logic        trigEn_q, trigEn_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        start_q, start_d;
   logic        trigger_q, trigger_d;
   logic [31:0] cycles_q, cycles_d;
   logic        startReq;
   logic        startAcc;
   logic        doneEvt;

   sca_axil_slave_if #(
      .ADDR_W (C_S_AXI_ADDR_WIDTH)
   ) u_slave (
      .ACLK    (ACLK),
      .ARESET  (ARESET),
      .S_AXI   (S_AXI),
      .wr_en   (wr_en),
      .wr_idx  (wr_idx),
      .wr_data (wr_data),
      .wr_strb (wr_strb),
      .wr_err  (wr_err),
      .rd_en   (rd_en),
      .rd_idx  (rd_idx),
      .rd_data (rdData),
      .rd_err  (rd_err)
   );

   assign wrSel      = int'(wr_idx);
   assign rdSel      = int'(rd_idx);
   assign core_key   = key_q;
   assign core_din   = pt_q;
   assign core_start = start_q;
   assign trigger    = trigger_q;

   // Register writes: CTRL always accepted, KEY/PT only while idle, everything else rejected.
   always_comb begin
      key_d    = key_q;
      pt_d     = pt_q;
      trigEn_d = trigEn_q;
      startReq = 1'b0;
      wr_err   = 1'b1;
      if (wrSel == REG_CTRL) begin
         wr_err = 1'b0;
      end else if (wrSel >= KB && wrSel < CB) begin
         wr_err = busy_q;
      end
      if (wr_en && !wr_err) begin
         if (wrSel == REG_CTRL && wr_strb[0]) begin
            trigEn_d = wr_data[CTRL_TRIG_EN];
            startReq = wr_data[CTRL_START];
         end
         for (int k = 0; k < KEY_WORDS; k++) begin
            if (wrSel == KB + k) key_d[k] = mergeStrb(key_q[k], wr_data, wr_strb);
         end
         for (int p = 0; p < BLK_WORDS; p++) begin
            if (wrSel == PB + p) pt_d[p] = mergeStrb(pt_q[p], wr_data, wr_strb);
         end
      end
   end

   // Run control: a completion while busy wins over any start; a start is only taken while idle.
   always_comb begin
      doneEvt  = core_done & busy_q;
      startAcc = startReq & ~busy_q;
      busy_d   = busy_q;
      done_d   = done_q;
      cycles_d = cycles_q;
      ct_d     = ct_q;
      if (busy_q && cycles_q != 32'hFFFF_FFFF) begin
         cycles_d = cycles_q + 32'd1;
      end
      if (doneEvt) begin
         busy_d = 1'b0;
         done_d = 1'b1;
         ct_d   = core_dout;
      end else if (startAcc) begin
         busy_d   = 1'b1;
         done_d   = 1'b0;
         cycles_d = '0;
      end
      start_d   = startAcc;
      trigger_d = trigEn_d & busy_d;
   end

   // Read mux, evaluated on the address handshake; unmapped indices read 0 with an error.
   always_comb begin
      rdData = '0;
      rd_err = 1'b0;
      if (rd_en) begin
         if (rdSel == REG_CTRL) begin
            rdData[CTRL_TRIG_EN] = trigEn_q;
         end else if (rdSel == REG_STATUS) begin
            rdData[STATUS_BUSY] = busy_q;
            rdData[STATUS_DONE] = done_q;
         end else if (rdSel == REG_CYCLES) begin
            rdData = cycles_q;
         end else if (rdSel == REG_ID) begin
            rdData = CORE_ID;
         end else if (rdSel < EB) begin
            for (int k = 0; k < KEY_WORDS; k++) begin
               if (rdSel == KB + k) rdData = key_q[k];
            end
            for (int p = 0; p < BLK_WORDS; p++) begin
               if (rdSel == PB + p) rdData = pt_q[p];
               if (rdSel == CB + p) rdData = ct_q[p];
            end
         end else begin
            rd_err = 1'b1;
         end
      end
   end

   // State registers; reset abandons any run in flight.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         key_q     <= '0;
         pt_q      <= '0;
         ct_q      <= '0;
         trigEn_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         start_q   <= 1'b0;
         trigger_q <= 1'b0;
         cycles_q  <= '0;
      end else begin
         key_q     <= key_d;
         pt_q      <= pt_d;
         ct_q      <= ct_d;
         trigEn_q  <= trigEn_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         start_q   <= start_d;
         trigger_q <= trigger_d;
         cycles_q  <= cycles_d;
      end
   end

endmodule

// File: tb/tb_sca_axil_cipher_regif.sv
// Directed bench for the AXI4-Lite cipher register front end with a simple
// fixed-latency cipher core model.
module tb_sca_axil_cipher_regif;

   localparam int          AW      = 8;
   localparam logic [31:0] CORE_ID = 32'hC1F0_0128;
   localparam logic [1:0]  OKAY    = 2'b00;
   localparam logic [1:0]  SLVERR  = 2'b10;

   logic clk = 1'b0;
   logic ARESET;
   logic core_start;
   logic [127:0] core_key;
   logic [127:0] core_din;
   logic core_done;
   logic [127:0] core_dout;
   logic trigger;

   int checks = 0;
   int errors = 0;
   int trigCount = 0;
   int startCount = 0;
   int hsCount = 0;

   logic [127:0] ctModel;

   sca_axil_cipher_regif_if #(.ADDR_W(AW)) bus ();

   sca_axil_cipher_regif #(
      .C_S_AXI_DATA_WIDTH (32),
      .C_S_AXI_ADDR_WIDTH (AW),
      .KEY_WORDS          (4),
      .BLK_WORDS          (4),
      .CORE_ID            (CORE_ID)
   ) dut (
      .ACLK       (clk),
      .ARESET     (ARESET),
      .S_AXI      (bus),
      .core_start (core_start),
      .core_key   (core_key),
      .core_din   (core_din),
      .core_done  (core_done),
      .core_dout  (core_dout),
      .trigger    (trigger)
   );

   always #5 clk = ~clk;

   // Cycle counters sampled mid-cycle.
   always @(negedge clk) begin
      trigCount  <= trigCount + int'(trigger);
      startCount <= startCount + int'(core_start);
      hsCount    <= hsCount + int'(bus.AWVALID & bus.AWREADY & bus.WVALID & bus.WREADY);
   end

   // Core model: done pulse 20 cycles after the start cycle (start cycle counted as 1).
   initial begin
      for (int i = 0; i < 4; i++) ctModel[32*i +: 32] = 32'hA5A5_0000 + 32'(i);
      core_done = 1'b0;
      core_dout = '1;
      forever begin
         @(posedge clk); #1;
         if (core_start === 1'b1) begin
            repeat (19) begin @(posedge clk); #1; end
            core_done = 1'b1;
            core_dout = ctModel;
            @(posedge clk); #1;
            core_done = 1'b0;
            core_dout = '1;
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [AW-1:0] addrOf(input int idx);
      return AW'(idx * 4);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input string tag, input logic [AW-1:0] addr, input logic [31:0] data,
                                input logic [3:0] strb, output logic [1:0] resp);
      int n;
      bus.AWADDR  = addr;
      bus.AWVALID = 1'b1;
      bus.WDATA   = data;
      bus.WSTRB   = strb;
      bus.WVALID  = 1'b1;
      bus.BREADY  = 1'b1;
      n = 0;
      while (bus.AWREADY !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      bus.AWVALID = 1'b0;
      bus.WVALID  = 1'b0;
      n = 0;
      while (bus.BVALID !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      checkOutput({tag, "_bvalid"}, 32'(bus.BVALID), 32'd1);
      resp = bus.BRESP;
      @(posedge clk); #1;
      bus.BREADY = 1'b0;
   endtask

   task automatic axiRead(input string tag, input logic [AW-1:0] addr,
                          output logic [31:0] data, output logic [1:0] resp);
      int n;
      bus.ARADDR  = addr;
      bus.ARVALID = 1'b1;
      bus.RREADY  = 1'b1;
      n = 0;
      while (bus.ARREADY !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      bus.ARVALID = 1'b0;
      n = 0;
      while (bus.RVALID !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      checkOutput({tag, "_rvalid"}, 32'(bus.RVALID), 32'd1);
      data = bus.RDATA;
      resp = bus.RRESP;
      @(posedge clk); #1;
      bus.RREADY = 1'b0;
   endtask

   task automatic writeCheck(input string tag, input int idx, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] expResp);
      logic [1:0] resp;
      applyStimulus(tag, addrOf(idx), data, strb, resp);
      checkOutput({tag, "_bresp"}, 32'(resp), 32'(expResp));
   endtask

   task automatic readCheck(input string tag, input logic [AW-1:0] addr,
                            input logic [31:0] expData, input logic [1:0] expResp);
      logic [31:0] data;
      logic [1:0]  resp;
      axiRead(tag, addr, data, resp);
      checkOutput({tag, "_rdata"}, data, expData);
      checkOutput({tag, "_rresp"}, 32'(resp), 32'(expResp));
   endtask

   initial begin
      int n;
      int t0;
      int s0;
      int h0;
      int bvHigh;

      ARESET      = 1'b1;
      bus.AWADDR  = '0;
      bus.AWPROT  = '0;
      bus.AWVALID = 1'b0;
      bus.WDATA   = '0;
      bus.WSTRB   = '0;
      bus.WVALID  = 1'b0;
      bus.BREADY  = 1'b0;
      bus.ARADDR  = '0;
      bus.ARPROT  = '0;
      bus.ARVALID = 1'b0;
      bus.RREADY  = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Reset state
      checkOutput("rst_ready_valid", {27'b0, bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID}, 32'd0);
      checkOutput("rst_rdata", bus.RDATA, 32'd0);
      checkOutput("rst_resp", {28'b0, bus.BRESP, bus.RRESP}, 32'd0);
      checkOutput("rst_start_trigger", {30'b0, core_start, trigger}, 32'd0);
      checkOutput("rst_key_din_zero", {31'b0, (core_key != '0) || (core_din != '0)}, 32'd0);

      ARESET = 1'b0;
      @(posedge clk); #1;
      readCheck("id", addrOf(3), CORE_ID, OKAY);
      readCheck("status_idle", addrOf(1), 32'd0, OKAY);

      // Key / plaintext readback
      for (int i = 0; i < 4; i++) writeCheck($sformatf("key%0d_wr", i), 4 + i, 32'(i + 1), 4'hF, OKAY);
      for (int i = 0; i < 4; i++) writeCheck($sformatf("pt%0d_wr", i), 8 + i, 32'(i + 5), 4'hF, OKAY);
      for (int i = 0; i < 4; i++) readCheck($sformatf("key%0d_rd", i), addrOf(4 + i), 32'(i + 1), OKAY);
      for (int i = 0; i < 4; i++) readCheck($sformatf("pt%0d_rd", i), addrOf(8 + i), 32'(i + 5), OKAY);
      checkOutput("core_key_w0", core_key[31:0], 32'd1);
      checkOutput("core_key_w3", core_key[127:96], 32'd4);
      checkOutput("core_din_w0", core_din[31:0], 32'd5);
      checkOutput("core_din_w3", core_din[127:96], 32'd8);

      // Full run with trigger enabled
      t0 = trigCount;
      s0 = startCount;
      writeCheck("run_ctrl_wr", 0, 32'h3, 4'hF, OKAY);
      repeat (30) @(posedge clk);
      #1;
      checkOutput("run_trigger_cycles", 32'(trigCount - t0), 32'd20);
      checkOutput("run_start_pulses", 32'(startCount - s0), 32'd1);
      readCheck("run_cycles", addrOf(2), 32'd20, OKAY);
      readCheck("run_status", addrOf(1), 32'h2, OKAY);
      readCheck("run_ctrl", addrOf(0), 32'h2, OKAY);
      for (int i = 0; i < 4; i++) readCheck($sformatf("run_ct%0d", i), addrOf(12 + i), 32'hA5A5_0000 + 32'(i), OKAY);

      // Busy protection
      s0 = startCount;
      writeCheck("busy_start_wr", 0, 32'h3, 4'hF, OKAY);
      readCheck("busy_status", addrOf(1), 32'h1, OKAY);
      writeCheck("busy_key0_wr", 4, 32'hDEAD_BEEF, 4'hF, SLVERR);
      writeCheck("busy_pt0_wr", 8, 32'hDEAD_BEEF, 4'hF, SLVERR);
      writeCheck("busy_restart_wr", 0, 32'h3, 4'hF, OKAY);
      readCheck("busy_key0_rd", addrOf(4), 32'd1, OKAY);
      checkOutput("busy_core_key_w0", core_key[31:0], 32'd1);
      repeat (30) @(posedge clk);
      #1;
      checkOutput("busy_start_pulses", 32'(startCount - s0), 32'd1);
      readCheck("busy_cycles", addrOf(2), 32'd20, OKAY);
      readCheck("busy_pt0_rd", addrOf(8), 32'd5, OKAY);

      // Strobes and error responses
      writeCheck("strb_key0_wr", 4, 32'h0000_AB00, 4'h2, OKAY);
      readCheck("strb_key0_rd", addrOf(4), 32'h0000_AB01, OKAY);
      readCheck("addr_lsb_ignored", 8'h13, 32'h0000_AB01, OKAY);
      writeCheck("cycles_wr", 2, 32'h0000_1234, 4'hF, SLVERR);
      readCheck("cycles_after_wr", addrOf(2), 32'd20, OKAY);
      writeCheck("ct0_wr", 12, 32'h0, 4'hF, SLVERR);
      readCheck("ct0_after_wr", addrOf(12), 32'hA5A5_0000, OKAY);
      readCheck("unmapped_rd", addrOf(63), 32'd0, SLVERR);
      writeCheck("unmapped_wr", 40, 32'h1, 4'hF, SLVERR);

      // Channel ordering: W three cycles ahead of AW, BREADY held low
      h0 = hsCount;
      bus.WDATA  = 32'h1234_5678;
      bus.WSTRB  = 4'hF;
      bus.WVALID = 1'b1;
      bus.BREADY = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("order_wready_early", 32'(bus.WREADY), 32'd0);
      bus.AWADDR  = addrOf(8);
      bus.AWVALID = 1'b1;
      n = 0;
      while (bus.AWREADY !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      checkOutput("order_awready", 32'(bus.AWREADY & bus.WREADY), 32'd1);
      @(posedge clk); #1;
      bus.AWVALID = 1'b0;
      bus.WVALID  = 1'b0;
      bvHigh = 0;
      repeat (5) begin
         if (bus.BVALID === 1'b1) bvHigh++;
         @(posedge clk); #1;
      end
      checkOutput("order_bvalid_held", 32'(bvHigh), 32'd5);
      checkOutput("order_bvalid_still", 32'(bus.BVALID), 32'd1);
      checkOutput("order_bresp", 32'(bus.BRESP), 32'(OKAY));
      bus.BREADY = 1'b1;
      @(posedge clk); #1;
      bus.BREADY = 1'b0;
      checkOutput("order_bvalid_cleared", 32'(bus.BVALID), 32'd0);
      checkOutput("order_handshakes", 32'(hsCount - h0), 32'd1);
      readCheck("order_pt0_rd", addrOf(8), 32'h1234_5678, OKAY);

      // Reset in the middle of a run, with a write response pending
      writeCheck("rstrun_start_wr", 0, 32'h3, 4'hF, OKAY);
      bus.AWADDR  = addrOf(4);
      bus.WDATA   = 32'hDEAD_BEEF;
      bus.WSTRB   = 4'hF;
      bus.AWVALID = 1'b1;
      bus.WVALID  = 1'b1;
      bus.BREADY  = 1'b0;
      n = 0;
      while (bus.AWREADY !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      bus.AWVALID = 1'b0;
      bus.WVALID  = 1'b0;
      @(posedge clk); #1;
      checkOutput("rstrun_bvalid_pending", 32'(bus.BVALID), 32'd1);
      checkOutput("rstrun_trigger_high", 32'(trigger), 32'd1);
      ARESET = 1'b1;
      #1;
      checkOutput("rstrun_bvalid_dropped", 32'(bus.BVALID), 32'd0);
      checkOutput("rstrun_trigger_low", 32'(trigger), 32'd0);
      checkOutput("rstrun_key_din_zero", {31'b0, (core_key != '0) || (core_din != '0)}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      ARESET = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      readCheck("rstrun_status", addrOf(1), 32'd0, OKAY);
      readCheck("rstrun_cycles", addrOf(2), 32'd0, OKAY);
      readCheck("rstrun_ctrl", addrOf(0), 32'd0, OKAY);
      readCheck("rstrun_ct0", addrOf(12), 32'd0, OKAY);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sca_axil_cipher_regif.md
# sca_axil_cipher_regif

Parametrised AXI4-Lite register front end for block-cipher cores in the side-channel evaluation designs, successor to the fixed 4-register AES-128 slave. It exposes configurable key, plaintext and ciphertext word banks plus control, status, cycle-count and ID registers. It drives a start/done handshake to the cipher core and a scope trigger that is high exactly while the core is busy. It sits between the AXI interconnect (driven by the AXI VIP master in simulation) and the cipher core.

## Interface
- C_S_AXI_DATA_WIDTH, 32: AXI data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 6: byte address width; must satisfy 2^C_S_AXI_ADDR_WIDTH >= 4*(4+KEY_WORDS+2*BLK_WORDS).
- KEY_WORDS, 4: 32-bit key words, 1..8.
- BLK_WORDS, 4: 32-bit words per plaintext/ciphertext block, 1..8.
- CORE_ID, 32'h0000_0000: constant returned by the ID register.
- ACLK  in  1  clock. Single clock domain.
- ARESET  in  1  reset, asynchronous, active-high.
- S_AXI_AW*/W*/B*/AR*/R*  AXI4-Lite slave  per AXI4-Lite spec  AWADDR/ARADDR are C_S_AXI_ADDR_WIDTH wide; WSTRB is 4 bits; AWPROT/ARPROT are ignored.
- core_start  out  1  one-cycle start pulse.
- core_key  out  32*KEY_WORDS  key bank; word 0 occupies the LSBs.
- core_din  out  32*BLK_WORDS  plaintext bank.
- core_done  in  1  one-cycle completion pulse from the core.
- core_dout  in  32*BLK_WORDS  ciphertext; valid when core_done is high.
- trigger  out  1  capture trigger for the oscilloscope.

## Operation
- Register index = addr[AW-1:2]; addr[1:0] are ignored.
- Index 0, CTRL: bit0 START (write-1 action, reads 0); bit1 TRIG_EN (RW, reset 0).
- Index 1, STATUS: bit0 BUSY and bit1 DONE (both RO). DONE is sticky and clears when a new start is accepted.
- Index 2, CYCLES: RO count of busy cycles in the last or current run.
- Index 3, ID: RO, returns CORE_ID.
- Index 4 .. 4+K-1: KEY, RW.
- Next BLK_WORDS indices: PT, RW.
- Next BLK_WORDS indices: CT, RO. Captured from core_dout on core_done.
- RW registers honour WSTRB per byte.
- Writes to KEY or PT while BUSY are discarded and answered with SLVERR. Writes to RO registers or unmapped indices are discarded and answered with SLVERR.
- Reads of unmapped indices return 0 with SLVERR. All other accesses respond OKAY.
- START=1 written while idle: core_start pulses, BUSY sets, DONE clears, CYCLES resets to 0.
- START=1 written while BUSY: ignored, response OKAY. The TRIG_EN bit in that same write still takes effect.
- While BUSY, CYCLES increments every cycle and saturates at 32'hFFFF_FFFF.
- core_done while BUSY: BUSY clears, DONE sets, CT captures core_dout. core_done while idle is ignored.
- trigger = TRIG_EN & BUSY, registered.

## Timing
- Reset values: all AXI ready/valid outputs 0, RDATA 0, BRESP/RRESP 0, core_start 0, trigger 0, every register 0.
- An asserted ARESET mid-transaction drops BVALID/RVALID immediately. A run in flight is abandoned; a later core_done is ignored.
- Write channel: AW and W may arrive in either order or together. AWREADY and WREADY pulse high together for one cycle once both are valid and no B response is pending.
- The register update takes effect on that handshake edge. BVALID rises the next cycle and holds until BREADY. Only one write is outstanding.
- Read channel: ARREADY pulses one cycle when ARVALID is high and RVALID is low. RVALID and RDATA follow one cycle later and hold until RREADY.
- A read and a write may be in flight simultaneously. If both target the same register on the same edge, the read returns the pre-write value.
- core_start is high in the cycle after the CTRL write handshake; BUSY and trigger rise in that same cycle.
- core_done in cycle N: BUSY, DONE and trigger are updated at N+1, and CT is readable from N+1.
- core_done coinciding with an accepted START: done is processed; the START is ignored.

## Structure
- Shared package sca_regif_pkg holds:
  - register index constants REG_CTRL, REG_STATUS, REG_CYCLES, REG_ID and base-index functions of KEY_WORDS/BLK_WORDS;
  - CTRL/STATUS bit positions;
  - AXI response codes RESP_OKAY and RESP_SLVERR.
- One sub-module, sca_axil_slave_if, handles AW/W joining, B/R holding and single-outstanding control. It presents wr_en/wr_idx/wr_data/wr_strb and rd_en/rd_idx, and accepts a per-access error flag.

## Test plan
- Key/PT readback: write KEY words 0x00000001..0x00000004 and PT words 0x00000005..0x00000008 at indices 4..11, then read them back -> each word matches, all responses OKAY.
- Full run: write CTRL=0x3, then the core model returns core_done after 20 cycles with CT=0xA5A5_0000+i -> trigger is high for exactly 20 cycles; CYCLES=20; STATUS=0x2; CT words read back A5A50000..A5A50003.
- Busy protection: during a run, write KEY0=0xDEADBEEF -> BRESP=SLVERR and KEY0 is unchanged. A second START has no effect, so core_start pulses exactly once.
- Strobes and errors: write WSTRB=0x2, data 0x0000AB00 to KEY0 -> only byte 1 changes. Write CYCLES and read index 0x3F -> SLVERR, and the unmapped read returns 0.
- Channel ordering: issue W 3 cycles before AW, and hold BREADY low for 5 cycles -> exactly one AWREADY/WREADY handshake, and BVALID stays high until BREADY.
- Reset mid-run: assert ARESET 5 cycles into a run -> all outputs return to 0; a subsequent core_done leaves STATUS=0.
